// File: rtl/reg_rename_file_if.sv
// Bundle between the decoder/ROB side and the rename register file: the global
// enable and flush, the two decoder read ports with their results, and the
// rename (issue) and commit (retire) requests from the reorder buffer.
interface reg_rename_file_if #(
    parameter int ROB_WIDTH = 4
);
    // Global control
    logic                 rdy;
    logic                 clear;

    // Decoder read ports
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 rs1_busy;
    logic [ROB_WIDTH-1:0] rs1_ROB_pos;
    logic [31:0]          rs1_val;
    logic                 rs2_busy;
    logic [ROB_WIDTH-1:0] rs2_ROB_pos;
    logic [31:0]          rs2_val;

    // Rename request from the ROB at issue
    logic                 update_ROB_valid;
    logic [ROB_WIDTH-1:0] update_ROB_pos;
    logic [4:0]           update_ROB_rd;

    // Retire request from the ROB at commit
    logic                 commit_valid;
    logic [ROB_WIDTH-1:0] commit_ROB_pos;
    logic [4:0]           commit_rd;
    logic [31:0]          new_val;

    // Decoder/ROB side: drives requests, receives read results
    modport master (
        output rdy, clear,
        output rs1, rs2,
        input  rs1_busy, rs1_ROB_pos, rs1_val,
        input  rs2_busy, rs2_ROB_pos, rs2_val,
        output update_ROB_valid, update_ROB_pos, update_ROB_rd,
        output commit_valid, commit_ROB_pos, commit_rd, new_val
    );

    // Register file side
    modport slave (
        input  rdy, clear,
        input  rs1, rs2,
        output rs1_busy, rs1_ROB_pos, rs1_val,
        output rs2_busy, rs2_ROB_pos, rs2_val,
        input  update_ROB_valid, update_ROB_pos, update_ROB_rd,
        input  commit_valid, commit_ROB_pos, commit_rd, new_val
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags. Each register
// holds its retired value, a busy flag and the ROB slot that will next write
// it. Reads are combinational and see a matching same-cycle commit through a
// bypass; same-cycle renames are deliberately invisible to reads so an
// issuing instruction reads its sources before its own destination rename.
module reg_rename_file #(
    parameter int ROB_WIDTH = 4,
    parameter int REG_NUM   = 32
) (
    input  logic              clk,
    input  logic              rst,
    reg_rename_file_if.slave  bus
);

    // Architectural state
    logic [31:0]          val_r  [REG_NUM];
    logic [REG_NUM-1:0]   busy_r;
    logic [ROB_WIDTH-1:0] tag_r  [REG_NUM];

    // Commit and rename qualifiers (x0 is never written)
    logic commit_wr;
    logic commit_match;
    logic rename_wr;

    assign commit_wr    = bus.commit_valid && (bus.commit_rd != 5'd0);
    assign commit_match = commit_wr && busy_r[bus.commit_rd]
                          && (tag_r[bus.commit_rd] == bus.commit_ROB_pos);
    // A flush kills the issuing instruction, so its rename never lands
    assign rename_wr    = bus.update_ROB_valid && (bus.update_ROB_rd != 5'd0)
                          && !bus.clear;

    // Read port 1: x0 constant, matching commit bypassed, else stored state
    always_comb begin
        bus.rs1_busy    = 1'b0;
        bus.rs1_ROB_pos = '0;
        bus.rs1_val     = '0;
        if (bus.rs1 != 5'd0) begin
            bus.rs1_ROB_pos = tag_r[bus.rs1];
            if (bus.commit_valid && (bus.commit_rd == bus.rs1) && busy_r[bus.rs1]
                && (tag_r[bus.rs1] == bus.commit_ROB_pos)) begin
                bus.rs1_busy = 1'b0;
                bus.rs1_val  = bus.new_val;
            end else begin
                bus.rs1_busy = busy_r[bus.rs1];
                bus.rs1_val  = val_r[bus.rs1];
            end
        end
    end

    // Read port 2: same resolution as port 1
    always_comb begin
        bus.rs2_busy    = 1'b0;
        bus.rs2_ROB_pos = '0;
        bus.rs2_val     = '0;
        if (bus.rs2 != 5'd0) begin
            bus.rs2_ROB_pos = tag_r[bus.rs2];
            if (bus.commit_valid && (bus.commit_rd == bus.rs2) && busy_r[bus.rs2]
                && (tag_r[bus.rs2] == bus.commit_ROB_pos)) begin
                bus.rs2_busy = 1'b0;
                bus.rs2_val  = bus.new_val;
            end else begin
                bus.rs2_busy = busy_r[bus.rs2];
                bus.rs2_val  = val_r[bus.rs2];
            end
        end
    end

    // Retired values: every commit writes, in order, regardless of tag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_r[i] <= '0;
            end
        end else if (bus.rdy) begin
            if (commit_wr) begin
                val_r[bus.commit_rd] <= bus.new_val;
            end
        end
    end

    // Busy flags: release on matching commit, rename overrides, flush clears all
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= '0;
        end else if (bus.rdy) begin
            if (bus.clear) begin
                busy_r <= '0;
            end else begin
                if (commit_match) begin
                    busy_r[bus.commit_rd] <= 1'b0;
                end
                if (rename_wr) begin
                    busy_r[bus.update_ROB_rd] <= 1'b1;
                end
            end
        end
    end

    // Rename tags: only a surviving rename updates them; stale tags are harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_r[i] <= '0;
            end
        end else if (bus.rdy) begin
            if (rename_wr) begin
                tag_r[bus.update_ROB_rd] <= bus.update_ROB_pos;
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: reset, rename/commit/bypass, stale
// commits, rename-vs-release, flush, rdy hold and x0 handling.
module tb_reg_rename_file;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    reg_rename_file_if #(.ROB_WIDTH(4)) bus ();

    reg_rename_file #(.ROB_WIDTH(4), .REG_NUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy              = 1'b1;
        bus.clear            = 1'b0;
        bus.update_ROB_valid = 1'b0;
        bus.update_ROB_pos   = '0;
        bus.update_ROB_rd    = '0;
        bus.commit_valid     = 1'b0;
        bus.commit_ROB_pos   = '0;
        bus.commit_rd        = '0;
        bus.new_val          = '0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] pos);
        bus.update_ROB_valid = 1'b1;
        bus.update_ROB_rd    = rd;
        bus.update_ROB_pos   = pos;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] pos, input logic [31:0] v);
        bus.commit_valid   = 1'b1;
        bus.commit_rd      = rd;
        bus.commit_ROB_pos = pos;
        bus.new_val        = v;
    endtask

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        idle();
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;

        // Reset applies even with rdy low
        rst     = 1'b1;
        bus.rdy = 1'b0;
        tick();
        tick();
        rst     = 1'b0;
        bus.rdy = 1'b1;
        bus.rs1 = 5'd5;
        bus.rs2 = 5'd0;
        #1;
        chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        chk("rst_rs1_val",  bus.rs1_val, 32'd0);
        chk("rst_rs1_pos",  32'(bus.rs1_ROB_pos), 32'd0);
        chk("rst_rs2_busy", 32'(bus.rs2_busy), 32'd0);
        chk("rst_rs2_val",  bus.rs2_val, 32'd0);

        // Rename x5 -> slot 3; not visible in the same cycle
        rename(5'd5, 4'd3);
        #1;
        chk("ren5_same_cycle_busy", 32'(bus.rs1_busy), 32'd0);
        tick();
        idle();
        #1;
        chk("ren5_busy", 32'(bus.rs1_busy), 32'd1);
        chk("ren5_pos",  32'(bus.rs1_ROB_pos), 32'd3);

        // Commit x5 slot 3: bypass in the same cycle, then stored
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1;
        chk("byp5_busy", 32'(bus.rs1_busy), 32'd0);
        chk("byp5_val",  bus.rs1_val, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("st5_busy", 32'(bus.rs1_busy), 32'd0);
        chk("st5_val",  bus.rs1_val, 32'hDEADBEEF);

        // x7 renamed twice; the older commit is stale
        bus.rs1 = 5'd7;
        rename(5'd7, 4'd2);
        tick();
        rename(5'd7, 4'd6);
        tick();
        idle();
        commit(5'd7, 4'd2, 32'h11);
        #1;
        chk("stale7_byp_busy", 32'(bus.rs1_busy), 32'd1);
        chk("stale7_byp_pos",  32'(bus.rs1_ROB_pos), 32'd6);
        tick();
        idle();
        #1;
        chk("stale7_busy", 32'(bus.rs1_busy), 32'd1);
        chk("stale7_pos",  32'(bus.rs1_ROB_pos), 32'd6);
        chk("stale7_val",  bus.rs1_val, 32'h11);
        commit(5'd7, 4'd6, 32'h22);
        #1;
        chk("match7_byp_busy", 32'(bus.rs1_busy), 32'd0);
        chk("match7_byp_val",  bus.rs1_val, 32'h22);
        tick();
        idle();
        #1;
        chk("match7_busy", 32'(bus.rs1_busy), 32'd0);
        chk("match7_val",  bus.rs1_val, 32'h22);

        // x9 on slot 1, then rename to slot 4 and commit slot 1 together
        bus.rs2 = 5'd9;
        rename(5'd9, 4'd1);
        tick();
        idle();
        rename(5'd9, 4'd4);
        commit(5'd9, 4'd1, 32'h55);
        #1;
        chk("both9_byp_busy", 32'(bus.rs2_busy), 32'd0);
        chk("both9_byp_val",  bus.rs2_val, 32'h55);
        tick();
        idle();
        #1;
        chk("both9_busy", 32'(bus.rs2_busy), 32'd1);
        chk("both9_pos",  32'(bus.rs2_ROB_pos), 32'd4);
        bus.clear = 1'b1;
        tick();
        idle();
        #1;
        chk("clr9_busy", 32'(bus.rs2_busy), 32'd0);
        chk("clr9_val",  bus.rs2_val, 32'h55);

        // x4 busy on slot 9, then rename x3 -> slot 8 under clear
        rename(5'd4, 4'd9);
        tick();
        idle();
        bus.rs1 = 5'd3;
        bus.rs2 = 5'd4;
        #1;
        chk("pre_clr4_busy", 32'(bus.rs2_busy), 32'd1);
        rename(5'd3, 4'd8);
        bus.clear = 1'b1;
        tick();
        idle();
        #1;
        chk("clr3_busy", 32'(bus.rs1_busy), 32'd0);
        chk("clr4_busy", 32'(bus.rs2_busy), 32'd0);

        // rdy low: rename, commit and clear all ignored
        rename(5'd12, 4'd7);
        tick();
        idle();
        bus.rdy   = 1'b0;
        bus.clear = 1'b1;
        rename(5'd10, 4'd5);
        commit(5'd11, 4'd0, 32'hAB);
        tick();
        idle();
        bus.rs1 = 5'd10;
        bus.rs2 = 5'd11;
        #1;
        chk("hold10_busy", 32'(bus.rs1_busy), 32'd0);
        chk("hold11_val",  bus.rs2_val, 32'd0);
        bus.rs1 = 5'd12;
        #1;
        chk("hold12_busy", 32'(bus.rs1_busy), 32'd1);
        chk("hold12_pos",  32'(bus.rs1_ROB_pos), 32'd7);

        // x0 stays zero under commit and rename
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        commit(5'd0, 4'd0, 32'hFF);
        rename(5'd0, 4'd5);
        #1;
        chk("x0_byp_val", bus.rs1_val, 32'd0);
        tick();
        idle();
        #1;
        chk("x0_busy", 32'(bus.rs1_busy), 32'd0);
        chk("x0_val",  bus.rs1_val, 32'd0);
        chk("x0_pos",  32'(bus.rs2_ROB_pos), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file with rename tags; sits between the decoder/issue stage and the reorder buffer.
- On issue, the reorder buffer announces a rename (rd -> ROB slot). The block marks that register busy and tags it with the slot.
- On commit, the reorder buffer writes the retired value here. The busy flag clears only if the register's tag still names the committing slot.
- The decoder reads rs1/rs2 each cycle and gets either a value or the ROB slot that will produce it.

Parameters:
- ROB_WIDTH, 4, width of a ROB slot index (16 slots).
- REG_NUM, 32, number of architectural registers; x0 is hardwired.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; when 0, all state holds and writes are ignored. Reads stay live.
- clear  in  1  mispredict flush; drops every pending rename.
- rs1  in  5  decoder source register 1.
- rs2  in  5  decoder source register 2.
- rs1_busy  out  1  1 = rs1 waits on a ROB slot.
- rs1_ROB_pos  out  ROB_WIDTH  tag of rs1; valid when rs1_busy=1.
- rs1_val  out  32  value of rs1; valid when rs1_busy=0.
- rs2_busy  out  1  as rs1_busy, for rs2.
- rs2_ROB_pos  out  ROB_WIDTH  as rs1_ROB_pos, for rs2.
- rs2_val  out  32  as rs1_val, for rs2.
- update_ROB_valid  in  1  rename of update_ROB_rd to update_ROB_pos this cycle.
- update_ROB_pos  in  ROB_WIDTH  ROB slot allocated to the issuing instruction.
- update_ROB_rd  in  5  destination register of the issuing instruction.
- commit_valid  in  1  ROB retires a register-writing instruction this cycle.
- commit_ROB_pos  in  ROB_WIDTH  slot being retired.
- commit_rd  in  5  destination register of the retired instruction.
- new_val  in  32  retired value.

Behaviour:
- State: val[0..31] (32b), busy[0..31], tag[0..31] (ROB_WIDTH).
- Reset (rst=1 at posedge, regardless of rdy): all val=0, busy=0, tag=0. Outputs then read busy=0, ROB_pos=0, val=0 for every register.
- Reads are combinational, evaluated per port:
  - Index 0: busy=0, val=0, ROB_pos=0.
  - Otherwise, if commit_valid && commit_rd==rsN && busy[rsN] && tag[rsN]==commit_ROB_pos: bypass. busy=0, val=new_val.
  - Otherwise: busy=busy[rsN], ROB_pos=tag[rsN], val=val[rsN].
  - The same-cycle update_ROB_* is NOT visible to reads. The issuing instruction reads its sources before its own rename.
- Sequential (posedge, rst=0, rdy=1):
  - Commit write: if commit_valid && commit_rd!=0, val[commit_rd]<=new_val unconditionally (architectural state, in order).
  - Commit release: if commit_valid && commit_rd!=0 && busy[commit_rd] && tag[commit_rd]==commit_ROB_pos, busy[commit_rd]<=0.
  - Rename: if update_ROB_valid && update_ROB_rd!=0, busy[update_ROB_rd]<=1 and tag[update_ROB_rd]<=update_ROB_pos.
  - Same register renamed and released in one cycle: the rename wins. busy stays 1 and the tag is the new slot; val still takes new_val.
  - Stale commit (tag mismatch): value written, busy untouched.
  - clear=1: every busy<=0; tags hold stale values, which are don't-care.
    - clear overrides a same-cycle rename, because that instruction is flushed.
    - A commit in the same cycle still writes val.
- Writes to register 0 are discarded in every path.
- Latency: a rename or commit is visible on reads the cycle after it is presented. A matching commit is also visible in the same cycle through the bypass.
- rdy=0: no state change. clear, update and commit are all ignored, and the ROB holds them as well.

Test Plan:
- Reset, then read rs1=5 and rs2=0 -> both busy=0, val=0.
- Rename x5->slot 3, next cycle read rs1=5 -> busy=1, ROB_pos=3. Commit x5 slot 3 with 0xDEADBEEF, same-cycle read -> busy=0, val=0xDEADBEEF (bypass). Following cycle the stored value gives the same result.
- Rename x7->slot 2 then x7->slot 6; commit x7 slot 2 val 0x11 -> val[7]=0x11 but x7 stays busy with ROB_pos=6. Commit slot 6 val 0x22 -> busy=0, val=0x22.
- Same cycle: rename x9->slot 4 and commit x9 slot 1 (tag was 1) with 0x55 -> next cycle x9 busy=1, ROB_pos=4, and read after a later clear gives 0x55.
- Rename x3->slot 8 with clear=1 in the same cycle, after x4 was busy on slot 9 -> next cycle x3 and x4 both busy=0.
- rdy=0 with rename x10 and commit x11 asserted -> no change. Write to x0 via commit (0xFF) and rename -> reads of x0 stay busy=0, val=0.
